fetch: RTL and testbench

Instruction fetch stage for the uRISC pipeline. It owns the architectural PC and EPC, issues one-at-a-time requests to instruction memory, and holds the fetched word in the IF/ID register with a one-entry skid buffer. It consumes the `*_idif_p1` control signals from the decode stage and the branch/jump-register redirect from execute to steer the PC. It drives `inst_ifid_p1`, `pc_p1` and `epc_p1` back into decode.

---
 rtl/urisc_pkg.sv | 27 ++
 rtl/fetch_if.sv | 18 +
 rtl/fetch_skid.sv | 48 ++++
 rtl/fetch.sv | 158 +++++++++++++++
 tb/tb_fetch.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/urisc_pkg.sv
// Shared uRISC encodings and small PC helpers used by the fetch stage and decode.
package urisc_pkg;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } fetch_state_e;

  localparam logic [15:0] NOP_INST = 16'h0800;

  // Major opcode field inst[15:12], shared with decode.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_J    = 4'h1;
  localparam logic [3:0] OP_RTI  = 4'h3;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'h5;

  function automatic logic [15:0] align_pc(input logic [15:0] pc);
    return {pc[15:1], 1'b0};
  endfunction

  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_if;
  logic        imem_req_valid_p1;
  logic        imem_req_ready_p1;
  logic [15:0] imem_req_addr_p1;
  logic        imem_rsp_valid_p1;
  logic [15:0] imem_rsp_data_p1;

  modport master (
    output imem_req_valid_p1, imem_req_addr_p1,
    input  imem_req_ready_p1, imem_rsp_valid_p1, imem_rsp_data_p1
  );

  modport slave (
    input  imem_req_valid_p1, imem_req_addr_p1,
    output imem_req_ready_p1, imem_rsp_valid_p1, imem_rsp_data_p1
  );
endinterface

// File: rtl/fetch_skid.sv
// One-entry {inst, pc} skid buffer behind the IF/ID register.
module fetch_skid
  import urisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc_in,
  output logic        full,
  output logic        full_next,
  output logic [15:0] inst_out,
  output logic [15:0] pc_out
);

  logic        full_q;
  logic [15:0] inst_q;
  logic [15:0] pc_q;

  // Load wins over unload so a same-cycle swap keeps the entry occupied.
  always_comb begin
    if (flush)       full_next = 1'b0;
    else if (load)   full_next = 1'b1;
    else if (unload) full_next = 1'b0;
    else             full_next = full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      inst_q <= NOP_INST;
      pc_q   <= '0;
    end else begin
      full_q <= full_next;
      if (load && !flush) begin
        inst_q <= inst_in;
        pc_q   <= pc_in;
      end
    end
  end

  assign full     = full_q;
  assign inst_out = inst_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/fetch.sv
// uRISC instruction fetch: owns PC/EPC, one outstanding imem request, IF/ID register plus skid.
module fetch
  import urisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall_idif_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        jmp_displacement_idif_p1,
  input  logic [15:0] jmp_displacement_value_idif_p1,
  input  logic        redirect_valid_ixif_p1,
  input  logic [15:0] redirect_pc_ixif_p1,
  output logic [15:0] inst_ifid_p1,
  output logic        inst_valid_ifid_p1,
  output logic [15:0] pc_p1,
  output logic [15:0] epc_p1,
  output logic        halted_p1
);

  fetch_state_e state_q, state_n;
  logic [15:0]  fetch_pc_q, fetch_pc_n, inst_q, inst_n, pc_q, pc_n, epc_q, epc_n;
  logic [15:0]  req_addr_q, target_raw, target;
  logic         drop_q, drop_n, ivalid_q, ivalid_n, halted_q, halted_n, req_valid_q;
  logic         consume, accept, rsp, rsp_take, in_halt, redir;
  logic         c_ill, c_rti, c_jmp, c_halt, new_pc, halt_evt, pending;
  logic         skid_load, skid_unload, skid_flush, skid_full, skid_full_next;
  logic [15:0]  skid_inst, skid_pc;

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .flush     (skid_flush),
    .inst_in   (imem.imem_rsp_data_p1),
    .pc_in     (fetch_pc_q),
    .full      (skid_full),
    .full_next (skid_full_next),
    .inst_out  (skid_inst),
    .pc_out    (skid_pc)
  );

  always_comb begin
    consume  = ivalid_q & ~stall_idif_p1;
    accept   = req_valid_q & imem.imem_req_ready_p1;
    rsp      = imem.imem_rsp_valid_p1;
    in_halt  = (state_q == ST_HALT);
    redir    = redirect_valid_ixif_p1 & ~in_halt;
    c_ill    = consume & illegal_op_idif_p1;
    c_rti    = consume & return_execution_idif_p1;
    c_jmp    = consume & jmp_displacement_idif_p1;
    c_halt   = consume & halt_idif_p1;
    new_pc   = redir | c_ill | c_rti | c_jmp;
    halt_evt = ~new_pc & c_halt;
    rsp_take = rsp & ~drop_q & (state_q == ST_WAIT);
    // A response is still owed after this cycle; it must be discarded when it lands.
    pending  = accept | (((state_q == ST_WAIT) | drop_q) & ~rsp);

    if (redir)      target_raw = redirect_pc_ixif_p1;
    else if (c_ill) target_raw = EXC_VECTOR;
    else if (c_rti) target_raw = epc_q;
    else            target_raw = pc_q + jmp_displacement_value_idif_p1;
    target = align_pc(target_raw);

    state_n     = state_q;
    fetch_pc_n  = fetch_pc_q;
    drop_n      = drop_q;
    inst_n      = inst_q;
    ivalid_n    = ivalid_q;
    pc_n        = pc_q;
    epc_n       = epc_q;
    halted_n    = halted_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (in_halt) begin
      if (rsp) drop_n = 1'b0;
    end else if (new_pc || halt_evt) begin
      ivalid_n   = 1'b0;
      inst_n     = NOP_INST;
      skid_flush = 1'b1;
      drop_n     = pending;
      if (new_pc) begin
        fetch_pc_n = target;
        state_n    = (accept || ((state_q == ST_WAIT) && !rsp)) ? ST_WAIT : ST_REQ;
        if (c_ill && !redir) epc_n = pc_q;
      end else begin
        state_n  = ST_HALT;
        halted_n = 1'b1;
      end
    end else begin
      if (accept) begin
        fetch_pc_n = pc_plus2(fetch_pc_q);
        state_n    = ST_WAIT;
      end
      if (rsp) begin
        drop_n = 1'b0;
        if (state_q == ST_WAIT) state_n = ST_REQ;
      end
      if (consume && skid_full) begin
        inst_n      = skid_inst;
        pc_n        = skid_pc;
        skid_unload = 1'b1;
        skid_load   = rsp_take;
      end else if (rsp_take && (!ivalid_q || consume)) begin
        inst_n   = imem.imem_rsp_data_p1;
        pc_n     = fetch_pc_q;
        ivalid_n = 1'b1;
      end else if (rsp_take) begin
        skid_load = 1'b1;
      end else if (consume) begin
        ivalid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      drop_q      <= (state_q == ST_WAIT) | ((state_q == ST_HALT) & drop_q);
      inst_q      <= NOP_INST;
      ivalid_q    <= 1'b0;
      pc_q        <= pc_plus2(RESET_PC);
      epc_q       <= '0;
      halted_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
    end else begin
      state_q     <= state_n;
      fetch_pc_q  <= fetch_pc_n;
      drop_q      <= drop_n;
      inst_q      <= inst_n;
      ivalid_q    <= ivalid_n;
      pc_q        <= pc_n;
      epc_q       <= epc_n;
      halted_q    <= halted_n;
      req_valid_q <= (state_n == ST_REQ) & ~skid_full_next;
      req_addr_q  <= fetch_pc_n;
    end
  end

  assign imem.imem_req_valid_p1 = req_valid_q;
  assign imem.imem_req_addr_p1  = req_addr_q;
  assign inst_ifid_p1           = inst_q;
  assign inst_valid_ifid_p1     = ivalid_q;
  assign pc_p1                  = pc_q;
  assign epc_p1                 = epc_q;
  assign halted_p1              = halted_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: imem model with configurable latency and a tiny opcode decoder.
module tb_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if imem ();

  logic        stall, redir_v;
  logic [15:0] redir_pc;
  logic        halt_c, ill_c, rti_c, jmp_c;
  logic [15:0] disp;
  logic [15:0] inst, pc, epc;
  logic        inst_valid, halted;

  fetch #(.RESET_PC(16'h0000), .EXC_VECTOR(16'h0002)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .imem                           (imem),
    .stall_idif_p1                  (stall),
    .halt_idif_p1                   (halt_c),
    .illegal_op_idif_p1             (ill_c),
    .return_execution_idif_p1       (rti_c),
    .jmp_displacement_idif_p1       (jmp_c),
    .jmp_displacement_value_idif_p1 (disp),
    .redirect_valid_ixif_p1         (redir_v),
    .redirect_pc_ixif_p1            (redir_pc),
    .inst_ifid_p1                   (inst),
    .inst_valid_ifid_p1             (inst_valid),
    .pc_p1                          (pc),
    .epc_p1                         (epc),
    .halted_p1                      (halted)
  );

  localparam logic [15:0] W_J    = 16'h1FFC;
  localparam logic [15:0] W_ILL  = 16'h2000;
  localparam logic [15:0] W_RTI  = 16'h3000;
  localparam logic [15:0] W_HALT = 16'h5000;

  assign jmp_c  = (inst[15:12] == 4'h1);
  assign ill_c  = (inst[15:12] == 4'h2);
  assign rti_c  = (inst[15:12] == 4'h3);
  assign halt_c = (inst[15:12] == 4'h5);
  assign disp   = {{4{inst[11]}}, inst[11:0]};

  logic [15:0] prog [0:32767];
  int unsigned lat;
  logic        ready_en, busy;

  assign imem.imem_req_ready_p1 = ready_en & ~busy;

  initial begin
    logic [15:0] a;
    busy = 1'b0;
    imem.imem_rsp_valid_p1 = 1'b0;
    imem.imem_rsp_data_p1  = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem.imem_req_valid_p1 && imem.imem_req_ready_p1) begin
        a = imem.imem_req_addr_p1;
        @(posedge clk); #1 busy = 1'b1;
        repeat (lat - 1) begin @(posedge clk); #1; end
        imem.imem_rsp_valid_p1 = 1'b1;
        imem.imem_rsp_data_p1  = prog[a[15:1]];
        @(posedge clk); #1;
        imem.imem_rsp_valid_p1 = 1'b0;
        busy = 1'b0;
      end
    end
  end

  logic [15:0] acc_q[$], cpc_q[$], cinst_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (imem.imem_req_valid_p1 && imem.imem_req_ready_p1) acc_q.push_back(imem.imem_req_addr_p1);
      if (inst_valid && !stall) begin
        cpc_q.push_back(pc);
        cinst_q.push_back(inst);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 32768; i++) prog[i] = 16'h4000 | 16'(i & 'hFFF);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    cpc_q.delete();
    cinst_q.delete();
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_cons(input logic [15:0] w, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (inst_valid && !stall && inst == w) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic found;
    rst = 1'b1; stall = 1'b1; redir_v = 1'b0; redir_pc = '0;
    lat = 1; ready_en = 1'b1;
    load_default();

    // Reset values, first-request latency and stall/skid behaviour.
    do_reset(3);
    @(negedge clk);
    check("rst_req_valid", imem.imem_req_valid_p1, 0);
    check("rst_inst", inst, 16'h0800);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_pc", pc, 16'h0002);
    check("rst_epc", epc, 16'h0000);
    check("rst_halted", halted, 0);
    @(negedge clk);
    check("first_req_valid", imem.imem_req_valid_p1, 1);
    check("first_req_addr", imem.imem_req_addr_p1, 16'h0000);
    @(negedge clk);
    check("wait_inst_valid", inst_valid, 0);
    @(negedge clk);
    check("first_inst_valid", inst_valid, 1);
    check("first_inst", inst, 16'h4000);
    check("first_pc", pc, 16'h0002);
    check("second_req_addr", imem.imem_req_addr_p1, 16'h0002);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (imem.imem_req_valid_p1 || !inst_valid || inst != 16'h4000 || pc != 16'h0002) ok = 1'b0;
    end
    check("stall_hold", ok, 1);
    @(posedge clk); #1 stall = 1'b0;
    repeat (30) @(negedge clk);
    check("stream_count", cpc_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_pc%0d", i), cpc_q[i], 16'(2 * i + 2));
      check($sformatf("stream_inst%0d", i), cinst_q[i], 16'(16'h4000 + i));
    end

    // Jump with negative displacement drops the in-flight fetch.
    prog[8] = W_J;
    do_reset(3);
    wait_cons(W_J, "j_seen");
    @(negedge clk);
    check("j_flush_valid", inst_valid, 0);
    repeat (12) @(negedge clk);
    check("j_log_size", (acc_q.size() >= 11) && (cpc_q.size() >= 10), 1);
    check("j_inflight_addr", acc_q[9], 16'h0012);
    check("j_target_addr", acc_q[10], 16'h000E);
    check("j_pc", cpc_q[8], 16'h0012);
    check("j_next_pc", cpc_q[9], 16'h0010);
    check("j_next_inst", cinst_q[9], 16'h4007);

    // Reset while a slow response is outstanding.
    lat = 6;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem.imem_req_valid_p1 && imem.imem_req_ready_p1) found = 1'b1;
    end
    check("midrst_accept", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    check("midrst_valid", found, 1);
    check("midrst_inst", inst, 16'h4000);
    check("midrst_pc", pc, 16'h0002);
    lat = 1;

    // IllegalOp saves EPC and vectors; RTI resumes at EPC.
    load_default();
    prog[16'h0010] = W_ILL;
    do_reset(3);
    wait_cons(W_ILL, "ill_seen");
    prog[1] = W_RTI;
    repeat (2) @(negedge clk);
    check("ill_epc", epc, 16'h0022);
    wait_cons(W_RTI, "rti_seen");
    repeat (8) @(negedge clk);
    check("ill_log_size", (acc_q.size() >= 21) && (cpc_q.size() >= 19), 1);
    check("ill_inflight_addr", acc_q[17], 16'h0022);
    check("ill_vector_addr", acc_q[18], 16'h0002);
    check("rti_target_addr", acc_q[20], 16'h0022);
    check("rti_pc", cpc_q[17], 16'h0004);
    check("rti_next_pc", cpc_q[18], 16'h0024);
    check("rti_epc_kept", epc, 16'h0022);

    // HALT is absorbing and ignores redirects.
    load_default();
    prog[3] = W_HALT;
    do_reset(3);
    wait_cons(W_HALT, "halt_seen");
    @(negedge clk);
    check("halt_flag", halted, 1);
    check("halt_valid", inst_valid, 0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (imem.imem_req_valid_p1 || inst_valid || !halted) ok = 1'b0;
    end
    check("halt_quiet", ok, 1);
    @(posedge clk); #1 redir_v = 1'b1; redir_pc = 16'h0040;
    @(posedge clk); #1 redir_v = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (imem.imem_req_valid_p1 || inst_valid || !halted) ok = 1'b0;
    end
    check("halt_redirect_ignored", ok, 1);
    check("halt_acc_count", acc_q.size(), 5);

    // Execute redirect beats a same-cycle decode jump; target bit 0 forced low.
    load_default();
    prog[8] = W_J;
    do_reset(3);
    wait_cons(W_J, "rj_seen");
    redir_v = 1'b1; redir_pc = 16'h0101;
    @(posedge clk); #1 redir_v = 1'b0;
    repeat (10) @(negedge clk);
    check("rj_log_size", (acc_q.size() >= 11) && (cpc_q.size() >= 10), 1);
    check("rj_target_addr", acc_q[10], 16'h0100);
    check("rj_next_pc", cpc_q[9], 16'h0102);
    check("rj_next_inst", cinst_q[9], 16'h4080);

    // PC wrap from 0xFFFE to 0x0000.
    @(posedge clk); #1 redir_v = 1'b1; redir_pc = 16'hFFFC;
    @(posedge clk); #1 redir_v = 1'b0;
    clear_logs();
    repeat (15) @(negedge clk);
    check("wrap_log_size", (acc_q.size() >= 3) && (cpc_q.size() >= 2), 1);
    check("wrap_addr0", acc_q[0], 16'hFFFC);
    check("wrap_addr1", acc_q[1], 16'hFFFE);
    check("wrap_addr2", acc_q[2], 16'h0000);
    check("wrap_pc0", cpc_q[0], 16'hFFFE);
    check("wrap_pc1", cpc_q[1], 16'h0000);
    check("wrap_inst1", cinst_q[1], 16'h4FFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
